// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for prog_loader.
// Handshake: a byte moves on a rising clk edge where byte_valid && byte_ready; the source holds byte_data stable while byte_valid is high and unaccepted.
interface prog_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a count-prefixed big-endian word stream into instruction memory from address 0, holding the CPU off meanwhile.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  prog_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CHK   = 3'd5,
`endif
    ST_FIN   = 3'd6
  } state_t;

  localparam logic [ADDR_W:0]   CAP      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              byte_ready_w;
  logic              xfer;
  logic              last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        acc_q, acc_d;
  logic              error_q, error_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      hi_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_q       <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      hi_q        <= hi_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_q       <= acc_d;
      error_q     <= error_d;
`endif
    end
  end

  // Ready is decoded from the registered state only, so there is no valid->ready path.
  always_comb begin
    byte_ready_w = 1'b0;
    case (state_q)
      ST_COUNT, ST_HI, ST_LO: byte_ready_w = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK:                 byte_ready_w = 1'b1;
`endif
      default:                byte_ready_w = 1'b0;
    endcase
  end

  assign xfer      = bus.byte_valid && byte_ready_w;
  assign last_word = (({1'b0, addr_q} + WORD_ONE) == count_q);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    hi_d        = hi_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    acc_d       = acc_q;
    error_d     = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COUNT;
          addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          acc_d   = '0;
          error_d = 1'b0;
`endif
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          // Zero and oversize counts both mean a full memory, so the address never wraps to 0.
          if (bus.byte_data == 8'h00 || 32'(bus.byte_data) > 32'(CAP)) begin
            count_d = CAP;
          end else begin
            count_d = (ADDR_W+1)'(bus.byte_data);
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          acc_d   = acc_q ^ bus.byte_data;
`endif
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (xfer) begin
          hi_d    = bus.byte_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          acc_d   = acc_q ^ bus.byte_data;
`endif
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (xfer) begin
          mem_addr_d  = addr_q;
          mem_wdata_d = {hi_q, bus.byte_data};
`ifdef PROG_LOADER_CHECKSUM_EN
          acc_d       = acc_q ^ bus.byte_data;
`endif
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + ADDR_ONE;
        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_FIN;
`endif
        end else begin
          state_d = ST_HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          if (bus.byte_data != acc_q) error_d = 1'b1;
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.byte_ready = byte_ready_w;
  assign bus.mem_we     = (state_q == ST_WRITE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign cpu_hold       = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done           = (state_q == ST_FIN);
  assign state_dbg      = state_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign error          = error_q;
`else
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte-stream driver, write scoreboard, and checking-task comparisons.
// Handles both builds, with and without PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cpu_hold, busy, done, error;
  logic [2:0] state_dbg;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected {addr, data} of every memory write, in order
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_e;
  logic [DATA_W-1:0]        mem_model [DEPTH];
  logic [DATA_W-1:0]        wbuf [DEPTH];
  int   cyc = 0, we_cnt = 0, done_cnt = 0, last_we_cyc = 0, done_cyc = 0;
  logic hold_at_done = 1'b1;
  logic [7:0] acc;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int WE_TO_DONE = 2;
`else
  localparam int WE_TO_DONE = 1;
`endif

  // Monitor samples 2 time units after each rising edge
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (bus.mem_we === 1'b1) begin
      we_cnt++;
      last_we_cyc = cyc;
      mem_model[bus.mem_addr] = bus.mem_wdata;
      check("write_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("write_addr_data", {bus.mem_addr, bus.mem_wdata}, exp_e);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      hold_at_done = cpu_hold;
    end
  end

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    int t;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    while (bus.byte_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("ready_timeout", (t < 100), 1'b1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_hold", cpu_hold, 1'b1);
    check("start_error_clear", error, 1'b0);
    check("start_state_count", state_dbg, 3'd1);
  endtask

  task automatic load(input logic [7:0] n, input int nw, input int maxgap,
                      input bit mid_start, input bit bad_chk);
    int t;
    we_cnt   = 0;
    done_cnt = 0;
    acc      = n;
    do_start();
    send_byte(n, maxgap);
    for (int i = 0; i < nw; i++) begin
      if (mid_start && i == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_busy", busy, 1'b1);
      end
      exp_q.push_back({ADDR_W'(i), wbuf[i]});
      send_byte(wbuf[i][15:8], maxgap);
      send_byte(wbuf[i][7:0], maxgap);
      acc = acc ^ wbuf[i][15:8] ^ wbuf[i][7:0];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? 8'h00 : acc, maxgap);
`endif
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", (t < 50), 1'b1);
    check("hold_low_at_done", hold_at_done, 1'b0);
    if (maxgap == 0) check("we_to_done_cycles", (done_cyc - last_we_cyc), WE_TO_DONE);
    @(negedge clk);
    check("done_single_cycle", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_hold", cpu_hold, 1'b0);
    check("idle_ready", bus.byte_ready, 1'b0);
    check("done_pulse_count", done_cnt, 1);
    check("write_count", we_cnt, nw);
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("error_flag", error, bad_chk);
`else
    check("error_flag", error, 1'b0);
`endif
  endtask

  int ready_seen;

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.byte_ready, 1'b0);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_addr", bus.mem_addr, 5'd0);
    check("rst_wdata", bus.mem_wdata, 16'h0000);
    check("rst_hold", cpu_hold, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two-word load: 02 12 34 AB CD
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'hABCD;
    load(8'h02, 2, 0, 1'b0, 1'b0);
    check("mem0_1234", mem_model[0], 16'h1234);
    check("mem1_abcd", mem_model[1], 16'hABCD);
    check("addr_holds", bus.mem_addr, 5'd1);
    check("wdata_holds", bus.mem_wdata, 16'hABCD);

    // Same stream with a wrong check byte; next start clears error
    load(8'h02, 2, 0, 1'b0, 1'b1);

    // Count 00 means full memory
    for (int i = 0; i < DEPTH; i++) wbuf[i] = {8'(i * 11 + 1), 8'(i) ^ 8'hF0};
    load(8'h00, 32, 0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) check("full_mem", mem_model[i], wbuf[i]);

    // Count 0x40 clamps to 32 words; the following byte stays unconsumed
    load(8'h40, 32, 0, 1'b0, 1'b0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hEE;
    ready_seen     = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) ready_seen++;
    end
    bus.byte_valid = 1'b0;
    check("clamp_unconsumed", ready_seen, 0);
    check("clamp_no_extra_write", we_cnt, 32);
    check("clamp_idle", busy, 1'b0);

    // Random gaps plus an ignored start mid-load
    wbuf[0] = 16'hC0DE;
    wbuf[1] = 16'h0F1E;
    wbuf[2] = 16'h7788;
    wbuf[3] = 16'hFFFF;
    load(8'h04, 4, 3, 1'b1, 1'b0);
    check("gap_mem3", mem_model[3], 16'hFFFF);

    // Reset between HI and LO of word 3
    for (int i = 0; i < 4; i++) wbuf[i] = 16'h1000 + 16'(i * 16'h0111);
    we_cnt = 0;
    do_start();
    send_byte(8'h05, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({ADDR_W'(i), wbuf[i]});
      send_byte(wbuf[i][15:8], 0);
      send_byte(wbuf[i][7:0], 0);
    end
    send_byte(wbuf[3][15:8], 0);
    check("pre_reset_state_lo", state_dbg, 3'd3);
    reset = 1'b1;
    #1;
    check("abort_we", bus.mem_we, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_hold", cpu_hold, 1'b0);
    check("abort_ready", bus.byte_ready, 1'b0);
    check("abort_state", state_dbg, 3'd0);
    check("abort_writes", we_cnt, 3);
    check("abort_scoreboard", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) check("abort_kept_mem", mem_model[i], wbuf[i]);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Fresh load after the abort
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'hABCD;
    load(8'h02, 2, 0, 1'b0, 1'b0);
    check("reload_mem0", mem_model[0], 16'h1234);
    check("reload_mem1", mem_model[1], 16'hABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
